div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// Two-requester scheduler sharing one pipelined unsigned divider.
// Ports: clk, rst_n, per-port req/resp handshakes, busy.

// div: fully pipelined restoring divider, no reset.
//   clk                 : clock
//   dividend, divisor   : operands, sampled every cycle
//   quotient, remainder : result LAT cycles after the operands
// Quotient bits are spread evenly over LAT stages.
module div #(
   parameter int N   = 32,
   parameter int LAT = N
) (
   input  logic         clk,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder
);

   genvar s;
   for (s = 0; s < LAT; s++) begin : stg
      localparam int LO = s * N / LAT;
      localparam int HI = (s + 1) * N / LAT;

      logic [N-1:0] a_i;
      logic [N-1:0] r_i;
      logic [N-1:0] d_i;
      logic [N-1:0] a_n;
      logic [N-1:0] r_n;
      logic [N:0]   t;
      logic [N-1:0] a_q;
      logic [N-1:0] r_q;

      if (s == 0) begin : src
         assign a_i = dividend;
         assign r_i = '0;
         assign d_i = divisor;
      end else begin : src
         assign a_i = stg[s-1].a_q;
         assign r_i = stg[s-1].r_q;
         assign d_i = stg[s-1].dp.d_q;
      end

      // a_n shifts the dividend out and quotient bits in.
      always_comb begin
         a_n = a_i;
         r_n = r_i;
         t   = '0;
         for (int k = LO; k < HI; k++) begin
            t   = {r_n, a_n[N-1]};
            a_n = {a_n[N-2:0], 1'b0};
            if (t >= {1'b0, d_i}) begin
               t      = t - {1'b0, d_i};
               a_n[0] = 1'b1;
            end
            r_n = t[N-1:0];
         end
      end

      always_ff @(posedge clk) begin
         a_q <= a_n;
         r_q <= r_n;
      end

      if (s < LAT - 1) begin : dp
         logic [N-1:0] d_q;
         always_ff @(posedge clk) begin
            d_q <= d_i;
         end
      end
   end

   assign quotient  = stg[LAT-1].a_q;
   assign remainder = stg[LAT-1].r_q;

endmodule

// div_sched: round-robin arbiter in front of a shared div.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid_k/ready_k   : request handshake, port k
//   dividend_k, divisor_k : unsigned operands, port k
//   resp_valid_k          : one-cycle result pulse, port k
//   quotient_k/remainder_k/dz_k : result, zero when not valid
//   busy                  : some operation is in flight
module div_sched #(
   parameter int N   = 32,
   parameter int LAT = N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid_0,
   input  logic         req_valid_1,
   output logic         req_ready_0,
   output logic         req_ready_1,
   input  logic [N-1:0] dividend_0,
   input  logic [N-1:0] dividend_1,
   input  logic [N-1:0] divisor_0,
   input  logic [N-1:0] divisor_1,
   output logic         resp_valid_0,
   output logic         resp_valid_1,
   output logic [N-1:0] quotient_0,
   output logic [N-1:0] quotient_1,
   output logic [N-1:0] remainder_0,
   output logic [N-1:0] remainder_1,
   output logic         dz_0,
   output logic         dz_1,
   output logic         busy
);

   // last_gnt is the port granted most recently; reset to 1 so
   // port 0 wins the first tie.
   logic           last_gnt;
   logic           gnt_0;
   logic           gnt_1;
   logic           issue;
   logic [N-1:0]   div_a;
   logic [N-1:0]   div_b;
   logic [N-1:0]   div_q;
   logic [N-1:0]   div_r;
   logic [LAT-1:0] sr_v;
   logic [LAT-1:0] sr_tag;
   logic [LAT-1:0] sr_dz;
   logic           out_v;
   logic           out_tag;
   logic           out_dz;
   logic [N-1:0]   res_q;
   logic [N-1:0]   res_r;

   assign gnt_0 = rst_n & req_valid_0 & (~req_valid_1 | last_gnt);
   assign gnt_1 = rst_n & req_valid_1 & (~req_valid_0 | ~last_gnt);
   assign issue = gnt_0 | gnt_1;

   assign req_ready_0 = gnt_0;
   assign req_ready_1 = gnt_1;

   assign div_a = gnt_1 ? dividend_1 : dividend_0;
   assign div_b = gnt_1 ? divisor_1  : divisor_0;

   div #(.N(N), .LAT(LAT)) u_div (
      .clk       (clk),
      .dividend  (div_a),
      .divisor   (div_b),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
         sr_v     <= '0;
         sr_tag   <= '0;
         sr_dz    <= '0;
      end else begin
         if (issue) last_gnt <= gnt_1;
         sr_v[0]   <= issue;
         sr_tag[0] <= gnt_1;
         sr_dz[0]  <= (div_b == '0);
         for (int i = 1; i < LAT; i++) begin
            sr_v[i]   <= sr_v[i-1];
            sr_tag[i] <= sr_tag[i-1];
            sr_dz[i]  <= sr_dz[i-1];
         end
      end
   end

   // Gate with rst_n so outputs are quiet in the reset cycle itself.
   assign out_v   = rst_n & sr_v[LAT-1];
   assign out_tag = sr_tag[LAT-1];
   assign out_dz  = sr_dz[LAT-1];
   assign busy    = rst_n & (|sr_v);

   assign res_q = out_dz ? '1 : div_q;
   assign res_r = out_dz ? '0 : div_r;

   assign resp_valid_0 = out_v & ~out_tag;
   assign resp_valid_1 = out_v &  out_tag;

   assign quotient_0  = resp_valid_0 ? res_q : '0;
   assign quotient_1  = resp_valid_1 ? res_q : '0;
   assign remainder_0 = resp_valid_0 ? res_r : '0;
   assign remainder_1 = resp_valid_1 ? res_r : '0;
   assign dz_0        = resp_valid_0 & out_dz;
   assign dz_1        = resp_valid_1 & out_dz;

endmodule
